// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_top: queues {parity_error, rx_data} on each rx_done
// rising edge and hands entries to the host one per accepted rd_en.
module uart_rx_fifo #(
    parameter int DATABITS = 8,
    parameter int DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATABITS-1:0]         rx_data,
    input  logic                        rx_done,
    input  logic                        parity_error,
    input  logic                        rd_en,
    output logic [DATABITS-1:0]         rd_data,
    output logic                        rd_perr,
    output logic                        rd_valid,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    input  logic                        ovf_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATABITS:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       count_nxt;
    logic              rx_done_d;
    logic              rx_armed;
    logic              wr_req, rd_acc, wr_acc, wr_drop;

    // rx_armed blocks a frame whose rx_done was already high when reset released.
    assign wr_req  = rx_done & ~rx_done_d & rx_armed;
    assign rd_acc  = rd_en & ~empty;
    assign wr_acc  = wr_req & (~full | rd_acc);
    assign wr_drop = wr_req & ~wr_acc;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wp] <= {parity_error, rx_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_d <= 1'b0;
            rx_armed  <= 1'b0;
        end else begin
            rx_done_d <= rx_done;
            rx_armed  <= rx_armed | ~rx_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (wr_acc) wp <= wp + PTR_ONE;
            if (rd_acc) rp <= rp + PTR_ONE;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_FULL);
        end
    end

    // When full with a simultaneous read, wp == rp: the read sees the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_perr  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc)
                {rd_perr, rd_data} <= mem[rp];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wr_drop)
            overflow <= 1'b1;
        else if (ovf_clear)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_error;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clear;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DATABITS(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .parity_error(parity_error), .rd_en(rd_en), .rd_data(rd_data),
        .rd_perr(rd_perr), .rd_valid(rd_valid), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored entries plus the sticky flag and last popped word.
    logic [8:0] exp_q[$];
    logic       exp_ovf;
    logic [7:0] exp_rd_data;
    logic       exp_rd_perr;
    logic       exp_rd_valid;
    logic       m_done_d;
    logic       m_seen_low;

    task automatic model_reset();
        exp_q.delete();
        exp_ovf      = 1'b0;
        exp_rd_data  = 8'h00;
        exp_rd_perr  = 1'b0;
        exp_rd_valid = 1'b0;
        m_done_d     = 1'b0;
        m_seen_low   = 1'b0;
    endtask

    // Drive one cycle of inputs from a negedge, apply the model at the posedge,
    // and return on the following negedge where outputs are sampled.
    task automatic step(input logic [7:0] d, input logic p, input logic dn,
                        input logic re, input logic clr);
        int  sz;
        bit  wr, rd, drop;
        rx_data = d; parity_error = p; rx_done = dn; rd_en = re; ovf_clear = clr;
        @(posedge clk);
        sz   = exp_q.size();
        wr   = dn && !m_done_d && m_seen_low;
        rd   = re && (sz > 0);
        drop = wr && !(sz < DEPTH || rd);
        exp_rd_valid = rd;
        if (rd) {exp_rd_perr, exp_rd_data} = exp_q.pop_front();
        if (wr && !drop) exp_q.push_back({p, d});
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        m_seen_low = m_seen_low | !dn;
        m_done_d   = dn;
        @(negedge clk);
    endtask

    task automatic write_frame(input logic [7:0] d, input logic p);
        step(d, p, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_data = 8'h00; parity_error = 1'b0; rx_done = 1'b0;
        rd_en = 1'b0; ovf_clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_data, rd_perr, rd_valid, empty, full, count, overflow} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got data=%h perr=%b vld=%b empty=%b full=%b count=%0d ovf=%b", rd_data, rd_perr, rd_valid, empty, full, count, overflow);
        end
        rx_done = 1'b1; @(negedge clk); rx_done = 1'b0; @(negedge clk);
        rx_data = 8'h99; rx_done = 1'b1; @(negedge clk);
        reset = 1'b1;
        repeat (3) step(8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_frame: got count=%0d empty=%b exp count=0 empty=1", count, empty);
        end
    endtask

    task automatic test_basic();
        write_frame(8'h55, 1'b0);
        write_frame(8'hA3, 1'b1);
        checks++;
        if (count !== 5'd2) begin errors++; $display("FAIL basic_count: got %0d exp 2", count); end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, rd_perr, rd_data} !== {1'b1, 1'b0, 8'h55}) begin
            errors++; $display("FAIL basic_read0: got vld=%b perr=%b data=%h exp 1/0/55", rd_valid, rd_perr, rd_data);
        end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, rd_perr, rd_data} !== {1'b1, 1'b1, 8'hA3}) begin
            errors++; $display("FAIL basic_read1: got vld=%b perr=%b data=%h exp 1/1/a3", rd_valid, rd_perr, rd_data);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL basic_after: got vld=%b empty=%b exp 0/1", rd_valid, empty);
        end
    endtask

    task automatic test_level();
        repeat (20) step(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd1) begin errors++; $display("FAIL level_count: got %0d exp 1", count); end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
            errors++; $display("FAIL level_data: got %h vld=%b exp 3c/1", rd_data, rd_valid);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) write_frame(8'(i), 1'b0);
        checks++;
        if ({full, overflow, count} !== {1'b1, 1'b1, 5'd16}) begin
            errors++; $display("FAIL ovf_state: got full=%b ovf=%b count=%0d exp 1/1/16", full, overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got %h vld=%b exp %h", i, rd_data, rd_valid, 8'(i));
            end
        end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h0F) begin
            errors++; $display("FAIL ovf_no_extra: got vld=%b empty=%b data=%h exp 0/1/0f", rd_valid, empty, rd_data);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
    endtask

    task automatic test_full_rw();
        logic [8:0] oldest;
        for (int i = 0; i < DEPTH; i++) write_frame(8'($urandom), 1'($urandom));
        oldest = exp_q[0];
        step(8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({count, overflow, rd_valid, rd_perr, rd_data} !== {5'd16, 1'b0, 1'b1, oldest}) begin
            errors++; $display("FAIL full_rw: got count=%0d ovf=%b vld=%b word=%h exp 16/0/1/%h", count, overflow, rd_valid, {rd_perr, rd_data}, oldest);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins: got ovf=%b exp 1", overflow); end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({rd_perr, rd_data} !== {exp_rd_perr, exp_rd_data}) begin
                errors++; $display("FAIL full_drain%0d: got %h exp %h", i, {rd_perr, rd_data}, {exp_rd_perr, exp_rd_data});
            end
        end
        checks++;
        if (rd_data !== 8'hEE) begin errors++; $display("FAIL full_last: got %h exp ee", rd_data); end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_empty_rw();
        logic [7:0] held;
        held = rd_data;
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== held) begin
            errors++; $display("FAIL empty_rd: got vld=%b data=%h exp 0/%h", rd_valid, rd_data, held);
        end
        step(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL empty_wr_rd: got count=%0d vld=%b exp 1/0", count, rd_valid);
        end
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({rd_valid, rd_perr, rd_data, empty} !== {1'b1, 1'b1, 8'h5A, 1'b1}) begin
            errors++; $display("FAIL empty_followup: got vld=%b perr=%b data=%h empty=%b exp 1/1/5a/1", rd_valid, rd_perr, rd_data, empty);
        end
    endtask

    task automatic test_mid_reset();
        write_frame(8'h11, 1'b0);
        write_frame(8'h22, 1'b1);
        rx_done = 1'b1; rx_data = 8'h33;
        #2 reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({count, empty, rd_valid, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset: got count=%0d empty=%b vld=%b ovf=%b", count, empty, rd_valid, overflow);
        end
        reset = 1'b1;
        step(8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL mid_reset_frame: got count=%0d exp 0", count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            step(8'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) < (c % 400 < 200 ? 1 : 3)), ($urandom_range(0, 15) == 0));
            checks++;
            if ({count, empty, full, overflow, rd_valid, rd_perr, rd_data} !==
                {5'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH, exp_ovf,
                 exp_rd_valid, exp_rd_perr, exp_rd_data}) begin
                errors++;
                $display("FAIL random_c%0d: got count=%0d e=%b f=%b ovf=%b vld=%b word=%h exp count=%0d ovf=%b vld=%b word=%h",
                         c, count, empty, full, overflow, rd_valid, {rd_perr, rd_data},
                         exp_q.size(), exp_ovf, exp_rd_valid, {exp_rd_perr, exp_rd_data});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
